racer_game_ctrl: RTL and testbench



---
 rtl/racer_pkg.sv | 28 ++
 rtl/racer_frame_cnt.sv | 29 ++
 rtl/racer_game_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_racer_game_ctrl.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/racer_pkg.sv
// Shared definitions for the racer game sequencer: state encodings, key bits, widths.
package racer_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        COUNTDOWN = 3'd1,
        RACE      = 3'd2,
        PAUSE     = 3'd3,
        OVER      = 3'd4
    } game_state_e;

    localparam int unsigned KEY_W     = 6;
    localparam int unsigned KEY_LEFT  = 0;
    localparam int unsigned KEY_RIGHT = 1;
    localparam int unsigned KEY_UP    = 2;
    localparam int unsigned KEY_DOWN  = 3;
    localparam int unsigned KEY_SPACE = 4;
    localparam int unsigned KEY_ESC   = 5;

    localparam int unsigned SCORE_W = 16;
    localparam int unsigned CD_W    = 8;

    // Keyboard events are honoured only when exactly one key bit is set.
    function automatic logic key_is_onehot(input logic [KEY_W-1:0] k);
        return $onehot(k);
    endfunction

endpackage

// File: rtl/racer_frame_cnt.sv
// Loadable frame down-counter: clear beats load beats tick; stops at zero.
module racer_frame_cnt #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         tick,
    output logic [W-1:0] count,
    output logic         zero_c
);

    assign zero_c = (count == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (tick && !zero_c) begin
            count <= count - W'(1);
        end
    end

endmodule

// File: rtl/racer_game_ctrl.sv
// Racer game sequencer: menu/countdown/race/pause/over FSM plus lane, speed and score.
// Define RACER_AUTO_ACCEL_EN to add automatic speed steps every ACCEL_FRAMES race ticks.
module racer_game_ctrl
    import racer_pkg::*;
#(
    parameter int unsigned LANES            = 3,
    parameter int unsigned SPEED_W          = 3,
    parameter int unsigned SPEED_MAX        = 7,
    parameter int unsigned COUNTDOWN_FRAMES = 180,
    parameter int unsigned ACCEL_FRAMES     = 120
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [KEY_W-1:0]          key_evt,
    input  logic                      frame_tick,
    input  logic                      collision,
    output logic [2:0]                game_state,
    output logic [$clog2(LANES)-1:0]  lane,
    output logic [SPEED_W-1:0]        speed,
    output logic [SCORE_W-1:0]        score,
    output logic [CD_W-1:0]           cd_frames,
    output logic                      race_start
);

    localparam int unsigned LANE_W  = $clog2(LANES);
    localparam int unsigned SUM_W   = SPEED_W + 2;
    localparam int unsigned SCORE_X = SCORE_W + 1;

    if (LANES < 2) begin : g_chk_lanes
        $error("LANES must be at least 2");
    end
    if (SPEED_MAX > (2 ** SPEED_W) - 1) begin : g_chk_speed
        $error("SPEED_MAX does not fit in SPEED_W bits");
    end
    if (COUNTDOWN_FRAMES > (2 ** CD_W) - 1) begin : g_chk_cd
        $error("COUNTDOWN_FRAMES does not fit in cd_frames");
    end
    if (ACCEL_FRAMES < 1) begin : g_chk_accel
        $error("ACCEL_FRAMES must be at least 1");
    end

    game_state_e state_q, state_d;

    logic key_ok_c, kl_c, kr_c, ku_c, kd_c, ks_c, ke_c;
    logic cd_clr, cd_load, cd_tick, cd_zero_c, cd_last_c;
    logic race_ok_c, race_tick_c, race_entry_c, auto_step_c;
    logic [LANE_W-1:0]        lane_d;
    logic [SPEED_W-1:0]       speed_d;
    logic [SCORE_W-1:0]       score_d;
    logic                     race_start_d;
    logic signed [SUM_W-1:0]  spd_sum;
    logic [SCORE_X-1:0]       score_sum;

    assign key_ok_c = key_is_onehot(key_evt);
    assign kl_c = key_ok_c && key_evt[KEY_LEFT];
    assign kr_c = key_ok_c && key_evt[KEY_RIGHT];
    assign ku_c = key_ok_c && key_evt[KEY_UP];
    assign kd_c = key_ok_c && key_evt[KEY_DOWN];
    assign ks_c = key_ok_c && key_evt[KEY_SPACE];
    assign ke_c = key_ok_c && key_evt[KEY_ESC];

    // Treat a zero count like the last frame so a zero-length countdown still exits.
    assign cd_last_c    = cd_zero_c || (cd_frames == CD_W'(1));
    assign race_entry_c = (state_q == COUNTDOWN) && !ke_c && frame_tick && cd_last_c;
    assign race_ok_c    = (state_q == RACE) && !collision && !ke_c && !ks_c;
    assign race_tick_c  = race_ok_c && frame_tick;

    racer_frame_cnt #(.W(CD_W)) u_cd_cnt (
        .clk      (clk),
        .rst      (rst),
        .clr      (cd_clr),
        .load     (cd_load),
        .load_val (CD_W'(COUNTDOWN_FRAMES)),
        .tick     (cd_tick),
        .count    (cd_frames),
        .zero_c   (cd_zero_c)
    );

`ifdef RACER_AUTO_ACCEL_EN
    localparam int unsigned ACC_W = $clog2(ACCEL_FRAMES + 1);

    logic [ACC_W-1:0] acc_count;
    logic             acc_zero_c;

    // Interval counter reloads on countdown exit and after each step; idle outside RACE.
    assign auto_step_c = race_tick_c && (acc_zero_c || (acc_count == ACC_W'(1)));

    racer_frame_cnt #(.W(ACC_W)) u_acc_cnt (
        .clk      (clk),
        .rst      (rst),
        .clr      (1'b0),
        .load     (race_entry_c || auto_step_c),
        .load_val (ACC_W'(ACCEL_FRAMES)),
        .tick     (race_tick_c),
        .count    (acc_count),
        .zero_c   (acc_zero_c)
    );
`else
    assign auto_step_c = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:      if (ks_c) state_d = COUNTDOWN;
            COUNTDOWN: if (ke_c) state_d = IDLE;
                       else if (race_entry_c) state_d = RACE;
            RACE:      if (collision) state_d = OVER;
                       else if (ke_c) state_d = IDLE;
                       else if (ks_c) state_d = PAUSE;
            PAUSE:     if (ks_c) state_d = RACE;
                       else if (ke_c) state_d = IDLE;
            OVER:      if (ks_c) state_d = COUNTDOWN;
                       else if (ke_c) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_comb begin
        lane_d       = lane;
        speed_d      = speed;
        score_d      = score;
        race_start_d = 1'b0;
        cd_clr       = 1'b0;
        cd_load      = 1'b0;
        cd_tick      = 1'b0;

        // Up/down and an auto step add together, then clamp to 0..SPEED_MAX.
        spd_sum = $signed({2'b00, speed});
        if (ku_c)        spd_sum = spd_sum + SUM_W'(1);
        if (kd_c)        spd_sum = spd_sum - SUM_W'(1);
        if (auto_step_c) spd_sum = spd_sum + SUM_W'(1);
        score_sum = {1'b0, score} + SCORE_X'(speed);

        unique case (state_q)
            IDLE, OVER: begin
                if (ks_c) begin
                    cd_load = 1'b1;
                    lane_d  = LANE_W'(LANES / 2);
                    speed_d = '0;
                    score_d = '0;
                end
            end
            COUNTDOWN: begin
                if (ke_c) begin
                    cd_clr = 1'b1;
                end else begin
                    cd_tick      = frame_tick;
                    race_start_d = race_entry_c;
                end
            end
            RACE: begin
                if (race_ok_c) begin
                    if (kl_c && lane != '0) lane_d = lane - LANE_W'(1);
                    if (kr_c && lane != LANE_W'(LANES - 1)) lane_d = lane + LANE_W'(1);
                    if (spd_sum[SUM_W-1]) begin
                        speed_d = '0;
                    end else if (spd_sum > $signed(SUM_W'(SPEED_MAX))) begin
                        speed_d = SPEED_W'(SPEED_MAX);
                    end else begin
                        speed_d = spd_sum[SPEED_W-1:0];
                    end
                    if (race_tick_c) begin
                        score_d = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lane       <= LANE_W'(LANES / 2);
            speed      <= '0;
            score      <= '0;
            race_start <= 1'b0;
        end else begin
            lane       <= lane_d;
            speed      <= speed_d;
            score      <= score_d;
            race_start <= race_start_d;
        end
    end

    assign game_state = state_q;

endmodule

// File: tb/tb_racer_game_ctrl.sv
// Randomised scoreboard bench for racer_game_ctrl against a behavioural game model.
module tb_racer_game_ctrl;

    localparam int LANES     = 3;
    localparam int SPEED_W   = 3;
    localparam int SPEED_MAX = 7;
    localparam int CDF       = 180;
    localparam int ACCEL     = 4;
`ifdef RACER_AUTO_ACCEL_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    localparam logic [5:0] K_LEFT  = 6'b000001;
    localparam logic [5:0] K_RIGHT = 6'b000010;
    localparam logic [5:0] K_UP    = 6'b000100;
    localparam logic [5:0] K_DOWN  = 6'b001000;
    localparam logic [5:0] K_SPACE = 6'b010000;
    localparam logic [5:0] K_ESC   = 6'b100000;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [5:0]   key_evt = '0;
    logic         frame_tick = 1'b0;
    logic         collision = 1'b0;
    logic [2:0]   game_state;
    logic [1:0]   lane;
    logic [2:0]   speed;
    logic [15:0]  score;
    logic [7:0]   cd_frames;
    logic         race_start;

    racer_game_ctrl #(
        .LANES(LANES), .SPEED_W(SPEED_W), .SPEED_MAX(SPEED_MAX),
        .COUNTDOWN_FRAMES(CDF), .ACCEL_FRAMES(ACCEL)
    ) dut (
        .clk(clk), .rst(rst), .key_evt(key_evt), .frame_tick(frame_tick),
        .collision(collision), .game_state(game_state), .lane(lane),
        .speed(speed), .score(score), .cd_frames(cd_frames), .race_start(race_start)
    );

    always #5 clk = ~clk;

    typedef struct {
        int st; int lane; int speed; int score; int cd; int rs;
    } exp_t;

    exp_t exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: 0 idle, 1 countdown, 2 race, 3 pause, 4 over.
    int m_st = 0, m_lane = LANES / 2, m_speed = 0, m_score = 0, m_cd = 0, m_rs = 0;
    int m_acc = 0;

    function automatic int clamp(input int v, input int lo, input int hi);
        return (v < lo) ? lo : ((v > hi) ? hi : v);
    endfunction

    function automatic void new_game();
        m_st = 1; m_cd = CDF; m_lane = LANES / 2; m_speed = 0; m_score = 0;
    endfunction

    function automatic void model_step(input bit r, input logic [5:0] k, input bit t, input bit c);
        bit ok, kl, kr, ku, kd, ks, ke;
        int d;
        ok = ($countones(k) == 1);
        kl = ok && k[0]; kr = ok && k[1]; ku = ok && k[2];
        kd = ok && k[3]; ks = ok && k[4]; ke = ok && k[5];
        if (r) begin
            m_st = 0; m_lane = LANES / 2; m_speed = 0; m_score = 0;
            m_cd = 0; m_rs = 0; m_acc = 0;
            return;
        end
        m_rs = 0;
        case (m_st)
            0: if (ks) new_game();
            1: begin
                if (ke) begin
                    m_st = 0; m_cd = 0;
                end else if (t) begin
                    if (m_cd <= 1) begin
                        m_cd = 0; m_st = 2; m_rs = 1; m_acc = 0;
                    end else begin
                        m_cd = m_cd - 1;
                    end
                end
            end
            2: begin
                if (c) m_st = 4;
                else if (ke) m_st = 0;
                else if (ks) m_st = 3;
                else begin
                    d = 0;
                    if (kl) m_lane = clamp(m_lane - 1, 0, LANES - 1);
                    if (kr) m_lane = clamp(m_lane + 1, 0, LANES - 1);
                    if (ku) d = 1;
                    if (kd) d = -1;
                    if (t) begin
                        m_score = clamp(m_score + m_speed, 0, 65535);
                        if (AUTO) begin
                            m_acc = m_acc + 1;
                            if (m_acc == ACCEL) begin
                                m_acc = 0;
                                d = d + 1;
                            end
                        end
                    end
                    m_speed = clamp(m_speed + d, 0, SPEED_MAX);
                end
            end
            3: begin
                if (ks) m_st = 2;
                else if (ke) m_st = 0;
            end
            4: begin
                if (ks) new_game();
                else if (ke) m_st = 0;
            end
            default: m_st = 0;
        endcase
    endfunction

    task automatic step(input bit r, input logic [5:0] k, input bit t, input bit c);
        exp_t e;
        @(negedge clk);
        rst = r; key_evt = k; frame_tick = t; collision = c;
        model_step(r, k, t, c);
        e.st = m_st; e.lane = m_lane; e.speed = m_speed;
        e.score = m_score; e.cd = m_cd; e.rs = m_rs;
        exp_q.push_back(e);
    endtask

    function automatic logic [5:0] rand_key();
        int r;
        r = int'($urandom_range(255, 0));
        if (r < 16) return K_LEFT;
        if (r < 32) return K_RIGHT;
        if (r < 48) return K_UP;
        if (r < 64) return K_DOWN;
        if (r < 70) return K_SPACE;
        if (r == 70) return K_ESC;
        if (r < 76) return 6'($urandom_range(63, 0));
        return 6'b000000;
    endfunction

    // Monitor: every clock presents one output set; compare it with the oldest expectation.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (int'(game_state) != e.st || int'(lane) != e.lane || int'(speed) != e.speed ||
                int'(score) != e.score || int'(cd_frames) != e.cd || int'(race_start) != e.rs) begin
                n_fail++;
                $display("FAIL outputs @%0t: got st=%0d lane=%0d speed=%0d score=%0d cd=%0d rs=%0d, expected st=%0d lane=%0d speed=%0d score=%0d cd=%0d rs=%0d",
                         $time, game_state, lane, speed, score, cd_frames, race_start,
                         e.st, e.lane, e.speed, e.score, e.cd, e.rs);
            end
        end
    end

    initial begin
        int budget;
        repeat (3) step(1'b1, 6'b0, 1'b0, 1'b0);

        // Countdown into race
        step(1'b0, K_SPACE, 1'b0, 1'b0);
        repeat (CDF) step(1'b0, 6'b0, 1'b1, 1'b0);
        step(1'b0, 6'b0, 1'b0, 1'b0);

        // Lane and speed saturation
        repeat (3) step(1'b0, K_LEFT, 1'b0, 1'b0);
        repeat (3) step(1'b0, K_RIGHT, 1'b0, 1'b0);
        repeat (9) step(1'b0, K_UP, 1'b0, 1'b0);
        repeat (2) step(1'b0, K_DOWN, 1'b0, 1'b0);
        repeat (10) step(1'b0, 6'b0, 1'b1, 1'b0);

        // Collision beats UP, then restart
        step(1'b0, K_UP, 1'b1, 1'b1);
        step(1'b0, 6'b0, 1'b1, 1'b0);
        step(1'b0, K_SPACE, 1'b0, 1'b0);
        repeat (CDF) step(1'b0, 6'b0, 1'b1, 1'b0);

        // Pause holds everything
        step(1'b0, K_UP, 1'b0, 1'b0);
        step(1'b0, K_SPACE, 1'b1, 1'b0);
        repeat (5) step(1'b0, 6'b0, 1'b1, 1'b1);
        step(1'b0, K_SPACE, 1'b0, 1'b0);
        step(1'b0, 6'b000011, 1'b1, 1'b0);
        step(1'b0, K_DOWN, 1'b0, 1'b0);

        // Auto-accel window (plain ticks in the default build)
        for (int i = 0; i < 16; i++) step(1'b0, (i == 15) ? K_UP : 6'b0, 1'b1, 1'b0);

        // Score saturation at 16'hFFFF
        repeat (7) step(1'b0, K_UP, 1'b0, 1'b0);
        repeat (9400) step(1'b0, 6'b0, 1'b1, 1'b0);

        // Reset in the middle of a race
        step(1'b1, K_LEFT, 1'b1, 1'b0);
        step(1'b0, 6'b0, 1'b0, 1'b0);

        // Randomised play
        for (int i = 0; i < 6000; i++) begin
            step(($urandom_range(1999, 0) == 0), rand_key(),
                 ($urandom_range(3, 0) != 0), ($urandom_range(127, 0) == 0));
        end
        step(1'b0, 6'b0, 1'b0, 1'b0);

        budget = 20;
        while (exp_q.size() != 0 && budget > 0) begin
            @(posedge clk);
            budget--;
        end
        #2;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
